// File: rtl/perf_fpga_stream_engine_pkg.sv
// lynxTypes: shared encodings for the stream perf engine.
//   LANE_BITS : width of one replicated pattern lane
//   TID_BITS  : width of the outbound stream tid field
//   REQ_*     : request type encodings presented on req_type
//   state_t   : engine FSM states
package lynxTypes;

  localparam int LANE_BITS = 64;
  localparam int TID_BITS  = 6;

  localparam logic [1:0] REQ_NONE  = 2'b00;
  localparam logic [1:0] REQ_READ  = 2'b01;
  localparam logic [1:0] REQ_WRITE = 2'b10;
  localparam logic [1:0] REQ_LOOP  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/perf_fpga_stream_engine_pattern_gen.sv
// perf_pattern_gen: lane-replicated beat pattern generator and checker.
//   idx      : current beat index
//   lane0_in : lane 0 of an inbound beat
//   pattern  : idx zero-extended to a lane and replicated across the bus
//   mismatch : lane0_in differs from the expected lane value
module perf_pattern_gen
  import lynxTypes::*;
#(
  parameter int DATA_BITS = 512,
  parameter int CNT_BITS  = 64
) (
  input  logic [CNT_BITS-1:0]  idx,
  input  logic [LANE_BITS-1:0] lane0_in,
  output logic [DATA_BITS-1:0] pattern,
  output logic                 mismatch
);

  logic [LANE_BITS-1:0] lane;

  assign lane     = LANE_BITS'(idx);
  assign pattern  = {(DATA_BITS / LANE_BITS){lane}};
  assign mismatch = (lane0_in != lane);

endmodule

// File: rtl/perf_fpga_stream_engine.sv
// perf_fpga_stream_engine: request-driven stream traffic engine.
// A request (read / write / loopback, n_beats) is accepted in IDLE, the
// transfer runs in RUN, and FIN pulses done for one cycle.
//   aclk, aresetn       : clock, synchronous active-low reset
//   axis_in_*           : inbound stream (read sink, loopback source)
//   axis_out_*          : outbound stream (write source, loopback sink)
//   req_valid/req_ready : request handshake, req_type and n_beats qualify it
//   busy, done          : in-progress flag and one-cycle completion pulse
//   cycles, err_cnt     : RUN cycle count and read mismatch count of the
//                         last request, held until the next accept
module perf_fpga_stream_engine
  import lynxTypes::*;
#(
  parameter int          DATA_BITS = 512,
  parameter int          CNT_BITS  = 64,
  parameter int unsigned TID_VAL   = 0
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   axis_in_tvalid,
  output logic                   axis_in_tready,
  input  logic [DATA_BITS-1:0]   axis_in_tdata,
  input  logic [DATA_BITS/8-1:0] axis_in_tkeep,
  input  logic                   axis_in_tlast,
  output logic                   axis_out_tvalid,
  input  logic                   axis_out_tready,
  output logic [DATA_BITS-1:0]   axis_out_tdata,
  output logic [DATA_BITS/8-1:0] axis_out_tkeep,
  output logic                   axis_out_tlast,
  output logic [TID_BITS-1:0]    axis_out_tid,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_type,
  input  logic [CNT_BITS-1:0]    n_beats,
  output logic                   busy,
  output logic                   done,
  output logic [63:0]            cycles,
  output logic [31:0]            err_cnt
);

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  state_t                state_q;
  logic [1:0]            mode_q;
  logic [CNT_BITS-1:0]   n_q;
  logic [CNT_BITS-1:0]   idx_q;
  logic [63:0]           cycles_q;
  logic [31:0]           err_q;

  logic                  run;
  logic                  last_beat;
  logic                  beat_hs;
  logic                  loop_sel;
  logic                  lane_mismatch;
  logic [DATA_BITS-1:0]  pattern;

  perf_pattern_gen #(
    .DATA_BITS (DATA_BITS),
    .CNT_BITS  (CNT_BITS)
  ) u_pattern (
    .idx      (idx_q),
    .lane0_in (axis_in_tdata[LANE_BITS-1:0]),
    .pattern  (pattern),
    .mismatch (lane_mismatch)
  );

  assign run       = (state_q == ST_RUN);
  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_FIN);
  assign cycles    = cycles_q;
  assign err_cnt   = err_q;
  assign last_beat = (idx_q == n_q - CNT_BITS'(1));
  assign loop_sel  = (mode_q == REQ_LOOP);

  // Stream handshake signals exist only while RUN; the unused side of the
  // current mode stays low.
  always_comb begin
    axis_out_tvalid = 1'b0;
    axis_in_tready  = 1'b0;
    if (run) begin
      case (mode_q)
        REQ_WRITE: axis_out_tvalid = 1'b1;
        REQ_READ:  axis_in_tready  = 1'b1;
        REQ_LOOP: begin
          axis_out_tvalid = axis_in_tvalid;
          axis_in_tready  = axis_out_tready;
        end
        default: ;
      endcase
    end
  end

  // In loopback the outbound handshake is the joint handshake, so only
  // read mode has to look at the inbound side.
  assign beat_hs = (mode_q == REQ_READ) ? (axis_in_tvalid && axis_in_tready)
                                        : (axis_out_tvalid && axis_out_tready);

  assign axis_out_tdata = loop_sel ? axis_in_tdata : pattern;
  assign axis_out_tkeep = loop_sel ? axis_in_tkeep : '1;
  assign axis_out_tlast = loop_sel ? axis_in_tlast : last_beat;
  assign axis_out_tid   = TID_BITS'(TID_VAL);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      cycles_q <= '0;
      err_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid && (req_type != REQ_NONE)) begin
            mode_q   <= req_type;
            n_q      <= n_beats;
            idx_q    <= '0;
            cycles_q <= '0;
            err_q    <= '0;
            state_q  <= (n_beats == '0) ? ST_FIN : ST_RUN;
          end
        end
        ST_RUN: begin
          cycles_q <= cycles_q + 64'd1;
          if (beat_hs) begin
            idx_q <= idx_q + CNT_BITS'(1);
            if ((mode_q == REQ_READ) && lane_mismatch) err_q <= sat_inc32(err_q);
            if (last_beat) state_q <= ST_FIN;
          end
        end
        ST_FIN:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_perf_fpga_stream_engine.sv
// Randomized and directed bench for perf_fpga_stream_engine with a
// transaction-level reference model checked on every cycle.
module tb_perf_fpga_stream_engine;
  import lynxTypes::*;

  localparam int DW   = 512;
  localparam int CW   = 64;
  localparam int KW   = DW / 8;
  localparam int TIDV = 5;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          axis_in_tvalid = 1'b0;
  logic          axis_in_tready;
  logic [DW-1:0] axis_in_tdata = '0;
  logic [KW-1:0] axis_in_tkeep = '0;
  logic          axis_in_tlast = 1'b0;
  logic          axis_out_tvalid;
  logic          axis_out_tready = 1'b0;
  logic [DW-1:0] axis_out_tdata;
  logic [KW-1:0] axis_out_tkeep;
  logic          axis_out_tlast;
  logic [TID_BITS-1:0] axis_out_tid;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_type = 2'b00;
  logic [CW-1:0] n_beats = '0;
  logic          busy;
  logic          done;
  logic [63:0]   cycles;
  logic [31:0]   err_cnt;

  perf_fpga_stream_engine #(
    .DATA_BITS (DW),
    .CNT_BITS  (CW),
    .TID_VAL   (TIDV)
  ) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .axis_in_tvalid  (axis_in_tvalid),
    .axis_in_tready  (axis_in_tready),
    .axis_in_tdata   (axis_in_tdata),
    .axis_in_tkeep   (axis_in_tkeep),
    .axis_in_tlast   (axis_in_tlast),
    .axis_out_tvalid (axis_out_tvalid),
    .axis_out_tready (axis_out_tready),
    .axis_out_tdata  (axis_out_tdata),
    .axis_out_tkeep  (axis_out_tkeep),
    .axis_out_tlast  (axis_out_tlast),
    .axis_out_tid    (axis_out_tid),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_type        (req_type),
    .n_beats         (n_beats),
    .busy            (busy),
    .done            (done),
    .cycles          (cycles),
    .err_cnt         (err_cnt)
  );

  always #5 aclk = ~aclk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int in_k = 0;
  bit in_hs_last = 1'b0;
  logic [DW-1:0] src_data [64];
  logic [DW-1:0] obs_data [$];
  bit            obs_last [$];

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rep(input logic [63:0] v);
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 64; i++) r[i*64 +: 64] = v;
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference model: a request is either absent, running (beats taken so
  // far = m_k) or finished-awaiting-done (m_fin).
  bit          m_busy = 1'b0;
  bit          m_fin = 1'b0;
  logic [1:0]  m_mode = 2'b00;
  logic [63:0] m_n = '0;
  logic [63:0] m_k = '0;
  logic [63:0] m_cyc = '0;
  logic [31:0] m_err = '0;

  always @(negedge aclk) begin
    bit e_run, e_otv, e_itr, hs;
    e_run = m_busy && !m_fin;
    e_otv = e_run && (m_mode == REQ_WRITE || (m_mode == REQ_LOOP && axis_in_tvalid));
    e_itr = e_run && (m_mode == REQ_READ  || (m_mode == REQ_LOOP && axis_out_tready));
    chk("req_ready", DW'(req_ready), DW'(!m_busy));
    chk("busy", DW'(busy), DW'(m_busy));
    chk("done", DW'(done), DW'(m_fin));
    chk("out_tvalid", DW'(axis_out_tvalid), DW'(e_otv));
    chk("in_tready", DW'(axis_in_tready), DW'(e_itr));
    chk("tid", DW'(axis_out_tid), DW'(TIDV));
    chk("cycles", DW'(cycles), DW'(m_cyc));
    chk("err_cnt", DW'(err_cnt), DW'(m_err));
    if (e_otv && m_mode == REQ_WRITE) begin
      chk("w_tdata", axis_out_tdata, rep(m_k));
      chk("w_tkeep", DW'(axis_out_tkeep), DW'({KW{1'b1}}));
      chk("w_tlast", DW'(axis_out_tlast), DW'(m_k == m_n - 64'd1));
    end
    if (e_otv && m_mode == REQ_LOOP) begin
      chk("l_tdata", axis_out_tdata, axis_in_tdata);
      chk("l_tkeep", DW'(axis_out_tkeep), DW'(axis_in_tkeep));
      chk("l_tlast", DW'(axis_out_tlast), DW'(axis_in_tlast));
    end
    if (aresetn && axis_out_tvalid && axis_out_tready) begin
      obs_data.push_back(axis_out_tdata);
      obs_last.push_back(axis_out_tlast);
    end
    if (aresetn && done) done_cnt++;
    in_hs_last = axis_in_tvalid && axis_in_tready;

    if (!aresetn) begin
      m_busy = 1'b0; m_fin = 1'b0; m_cyc = '0; m_err = '0; m_k = '0;
    end else if (!m_busy) begin
      if (req_valid && req_type != REQ_NONE) begin
        m_busy = 1'b1; m_mode = req_type; m_n = n_beats;
        m_k = '0; m_cyc = '0; m_err = '0; m_fin = (n_beats == '0);
      end
    end else if (m_fin) begin
      m_busy = 1'b0; m_fin = 1'b0;
    end else begin
      m_cyc = m_cyc + 64'd1;
      hs = (m_mode == REQ_READ) ? (axis_in_tvalid && e_itr) : (e_otv && axis_out_tready);
      if (hs) begin
        if (m_mode == REQ_READ && axis_in_tdata[63:0] != m_k && m_err != '1) m_err = m_err + 32'd1;
        m_k = m_k + 64'd1;
        if (m_k == m_n) m_fin = 1'b1;
      end
    end
  end

  task automatic drive_step(input int rc, input int rdy_mode, input int vld_mode);
    if (in_hs_last) in_k++;
    if (!axis_in_tvalid || in_hs_last) begin
      axis_in_tvalid = (vld_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      axis_in_tdata  = src_data[in_k % 64];
      axis_in_tkeep  = {$urandom, $urandom};
      axis_in_tlast  = 1'($urandom_range(0, 1));
    end
    case (rdy_mode)
      0:       axis_out_tready = 1'b1;
      1:       axis_out_tready = (rc % 2 == 0);
      default: axis_out_tready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic idle_cycle();
    @(posedge aclk); #2;
  endtask

  // Presents one request and runs it to done (or aborts with a reset once
  // abort_at inbound beats have been taken). lat counts cycles from the
  // accept cycle to the done cycle.
  task automatic run_req(input logic [1:0] t, input logic [63:0] n, input int rdy_mode,
                         input int vld_mode, input int abort_at, output int lat);
    int c0;
    int rc;
    bit fin;
    lat = -1; rc = 0; fin = 1'b0; in_k = 0;
    obs_data.delete(); obs_last.delete();
    req_valid = 1'b1; req_type = t; n_beats = n;
    @(posedge aclk); #2;
    req_valid = 1'b0; c0 = cyc;
    for (int b = 0; b < 400 && !fin; b++) begin
      if (done) begin
        lat = cyc - c0 + 1; fin = 1'b1;
      end else begin
        drive_step(rc, rdy_mode, vld_mode); rc++;
        if (abort_at >= 0 && in_k == abort_at) begin
          aresetn = 1'b0; axis_in_tvalid = 1'b0;
          @(posedge aclk); #2;
          aresetn = 1'b1; fin = 1'b1;
        end else begin
          @(posedge aclk); #2;
        end
      end
    end
    if (!fin) begin
      n_vec++; n_bad++;
      $display("FAIL req_timeout: got no done expected done within 400 cycles");
    end
    axis_in_tvalid = 1'b0; axis_out_tready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int d0;
    logic [63:0] rd4 [4];
    logic [1:0] t;
    logic [63:0] n;
    rd4[0] = 64'd0; rd4[1] = 64'd1; rd4[2] = 64'd7; rd4[3] = 64'd3;
    for (int i = 0; i < 64; i++) src_data[i] = '0;

    repeat (3) @(posedge aclk);
    #2;
    chk("rst_busy", DW'(busy), DW'(0));
    chk("rst_req_ready", DW'(req_ready), DW'(1));
    chk("rst_cycles", DW'(cycles), DW'(0));
    chk("rst_err", DW'(err_cnt), DW'(0));
    chk("rst_out_tvalid", DW'(axis_out_tvalid), DW'(0));
    aresetn = 1'b1;
    idle_cycle();

    // Write, 4 beats, sink always ready
    run_req(REQ_WRITE, 64'd4, 0, 0, -1, lat);
    chk("w4_latency", DW'(lat), DW'(5));
    chk("w4_cycles", DW'(cycles), DW'(4));
    chk("w4_beats", DW'(obs_data.size()), DW'(4));
    for (int i = 0; i < 4 && i < obs_data.size(); i++) begin
      chk("w4_lanes", obs_data[i], rep(64'(i)));
      chk("w4_tlast", DW'(obs_last[i]), DW'(i == 3));
    end
    idle_cycle();

    // Write, 3 beats, sink ready toggling 1/0
    run_req(REQ_WRITE, 64'd3, 1, 0, -1, lat);
    chk("w3_cycles", DW'(cycles), DW'(5));
    chk("w3_err", DW'(err_cnt), DW'(0));
    chk("w3_beats", DW'(obs_data.size()), DW'(3));
    idle_cycle();

    // Read, 4 beats, lane 0 = 0,1,7,3
    for (int i = 0; i < 4; i++) begin
      src_data[i] = rnd_word();
      src_data[i][63:0] = rd4[i];
    end
    d0 = done_cnt;
    run_req(REQ_READ, 64'd4, 0, 0, -1, lat);
    chk("r4_err", DW'(err_cnt), DW'(1));
    idle_cycle();
    chk("r4_done_once", DW'(done_cnt - d0), DW'(1));
    chk("r4_busy_after", DW'(busy), DW'(0));

    // Loopback, 2 beats, 0xAA.. then 0x55..
    src_data[0] = {64{8'hAA}};
    src_data[1] = {64{8'h55}};
    run_req(REQ_LOOP, 64'd2, 0, 0, -1, lat);
    chk("l2_latency", DW'(lat), DW'(3));
    chk("l2_cycles", DW'(cycles), DW'(2));
    chk("l2_beats", DW'(obs_data.size()), DW'(2));
    if (obs_data.size() == 2) begin
      chk("l2_beat0", obs_data[0], {64{8'hAA}});
      chk("l2_beat1", obs_data[1], {64{8'h55}});
    end
    idle_cycle();

    // Zero-beat write
    run_req(REQ_WRITE, 64'd0, 0, 0, -1, lat);
    chk("z_latency", DW'(lat), DW'(1));
    chk("z_cycles", DW'(cycles), DW'(0));
    chk("z_beats", DW'(obs_data.size()), DW'(0));
    idle_cycle();

    // Illegal request type is ignored
    d0 = done_cnt;
    req_valid = 1'b1; req_type = REQ_NONE; n_beats = 64'd5;
    for (int i = 0; i < 3; i++) begin
      idle_cycle();
      chk("ill_req_ready", DW'(req_ready), DW'(1));
      chk("ill_busy", DW'(busy), DW'(0));
    end
    req_valid = 1'b0;
    idle_cycle();
    chk("ill_no_done", DW'(done_cnt - d0), DW'(0));

    // Reset after 2 of 8 read beats, then a clean 8-beat read
    for (int i = 0; i < 8; i++) begin
      src_data[i] = rnd_word();
      src_data[i][63:0] = 64'(i);
    end
    d0 = done_cnt;
    run_req(REQ_READ, 64'd8, 0, 0, 2, lat);
    chk("abort_busy", DW'(busy), DW'(0));
    chk("abort_req_ready", DW'(req_ready), DW'(1));
    chk("abort_cycles", DW'(cycles), DW'(0));
    idle_cycle();
    idle_cycle();
    chk("abort_no_done", DW'(done_cnt - d0), DW'(0));
    run_req(REQ_READ, 64'd8, 0, 0, -1, lat);
    chk("re_err", DW'(err_cnt), DW'(0));
    chk("re_cycles", DW'(cycles), DW'(8));
    chk("re_latency", DW'(lat), DW'(9));
    idle_cycle();

    // Randomized requests against the model
    for (int r = 0; r < 40; r++) begin
      t = 2'($urandom_range(1, 3));
      n = 64'($urandom_range(0, 12));
      for (int i = 0; i < 64; i++) begin
        src_data[i] = rnd_word();
        if (t == REQ_READ && $urandom_range(0, 3) != 0) src_data[i][63:0] = 64'(i);
      end
      if ($urandom_range(0, 4) == 0) begin
        req_valid = 1'b1; req_type = REQ_NONE;
        idle_cycle();
        req_valid = 1'b0;
      end
      run_req(t, n, $urandom_range(0, 2), $urandom_range(0, 1), -1, lat);
      idle_cycle();
    end

    repeat (3) idle_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/perf_fpga_stream_engine.md
PERF_FPGA_STREAM_ENGINE -- requirements
Module: perf_fpga_stream_engine

Interface
REQ-001 The module SHALL have parameter DATA_BITS, default 512, meaning stream data width (multiple of 64).
REQ-002 The module SHALL have parameter CNT_BITS, default 64, meaning beat-count width.
REQ-003 The module SHALL have parameter TID_VAL, default 0, meaning constant tid driven on axis_out.
REQ-004 Port aclk  input  1  clock, all logic on rising edge.
REQ-005 Port aresetn  input  1  reset, synchronous, active-low.
REQ-006 Port axis_in  AXI4SR slave  DATA_BITS  inbound stream (read sink, loopback source).
REQ-007 Port axis_out  AXI4SR master  DATA_BITS  outbound stream (write source, loopback sink).
REQ-008 Port req_valid  input  1  request strobe.
REQ-009 Port req_ready  output  1  engine accepts request.
REQ-010 Port req_type  input  2  01 read, 10 write, 11 loopback, 00 illegal.
REQ-011 Port n_beats  input  CNT_BITS  beats to transfer.
REQ-012 Port busy  output  1  request in progress.
REQ-013 Port done  output  1  one-cycle completion pulse.
REQ-014 Port cycles  output  64  cycles from accept to final beat, held until next accept.
REQ-015 Port err_cnt  output  32  read-data mismatches of last request, saturating.

Function
REQ-016 FSM states SHALL be IDLE, RUN, FIN; req_ready = (state == IDLE).
REQ-017 Accept on req_valid && req_ready with req_type != 00: latch type and n_beats, clear cycles, err_cnt, beat index; go RUN, or FIN directly if n_beats == 0.
REQ-018 req_type 00 while IDLE SHALL be ignored (no accept, no done).
REQ-019 busy SHALL be 1 in RUN and FIN, 0 in IDLE.
REQ-020 Beat index idx (CNT_BITS) SHALL increment by 1 on each counted handshake; remaining = n_beats - idx.
REQ-021 Write: axis_out.tvalid = RUN; tdata = every 64-bit lane equals zero-extended idx; tkeep all ones; tlast = (idx == n_beats-1); axis_in.tready = 0.
REQ-022 Read: axis_in.tready = RUN; axis_out.tvalid = 0; each accepted beat whose lane 0 differs from idx SHALL increment err_cnt (saturate at 2^32-1).
REQ-023 Loopback: axis_out.tdata/tkeep/tlast = axis_in fields combinationally, axis_out.tvalid = RUN && axis_in.tvalid, axis_in.tready = RUN && axis_out.tready; count on the joint handshake.
REQ-024 axis_out.tid SHALL be TID_VAL at all times; tvalid SHALL not drop without handshake once asserted.
REQ-025 On the handshake with idx == n_beats-1 the FSM SHALL go RUN -> FIN; no further handshakes after that beat.
REQ-026 cycles SHALL increment every cycle in RUN, including the final-beat cycle; FIN cycle not counted.
REQ-027 FIN SHALL last exactly one cycle, assert done, then return to IDLE; req_ready rises the cycle after done.
REQ-028 n_beats == 0: done asserted the cycle after accept, cycles = 0, no stream handshakes.
REQ-029 Outside the mode in use, unused tvalid/tready SHALL be 0.

Reset
REQ-030 Reset SHALL force IDLE, busy=0, done=0, cycles=0, err_cnt=0, idx=0, all tvalid/tready 0, including mid-RUN (transfer abandoned, no done).

Structure
REQ-031 Mode encodings (REQ_READ, REQ_WRITE, REQ_LOOP) and the FSM state enum SHALL live in the shared lynxTypes package.
REQ-032 The lane-replicated pattern generator/checker SHALL be one sub-module, perf_pattern_gen (idx in, DATA_BITS pattern out, lane-0 mismatch out).

Verification
REQ-033 Write, n_beats=4, tready always 1 -> lanes carry 0,1,2,3; tlast only on beat 3; done 5 cycles after accept; cycles=4.
REQ-034 Write, n_beats=3, tready toggling 1/0 -> tdata stable while stalled, 3 beats, cycles=5, err_cnt=0.
REQ-035 Read, n_beats=4, lane-0 data 0,1,7,3 -> err_cnt=1, done pulse once, busy low after.
REQ-036 Loopback, n_beats=2, input data 0xAA.., 0x55.. -> identical data on axis_out, done after 2nd joint handshake.
REQ-037 n_beats=0 write -> done the cycle after accept, no tvalid, cycles=0; req_type=00 -> req_ready stays 1, no done.
REQ-038 Reset asserted after 2 of 8 read beats -> IDLE next cycle, no done, new request accepted and completes normally.
